// File: rtl/noise_mix_dac.sv
// ---------------------------------------------------------------------------
// noise_mix_dac
//
// Front end of the audio filter chain. It produces the sample-rate clock
// enable, generates 16-bit LFSR noise, mixes tone / scaled noise / filtered
// input under mode control with saturation, and formats the mixed sample as an
// offset-binary code for an 8-bit (parametrisable) PMOD DAC.
//
// Pipeline, relative to a cycle n in which en is high:
//   edge ending cycle n   : stage A captures tone_in, filt_in, mode and the
//                           shifted noise; the LFSR advances
//   edge ending cycle n+1 : stage B selects / saturates into mix_out
//                           (mix_out and mix_valid visible in cycle n+2)
//   edge ending cycle n+2 : stage C formats mix_out into dac_out
//                           (dac_out visible in cycle n+3)
//
// Output strobe: mix_valid is a one-cycle strobe with no back-pressure; it is
// high in exactly the cycles in which mix_out holds a freshly produced sample.
// mix_out holds its last value while mix_valid is low. Every downstream
// consumer must take the sample in the strobe cycle.
//
// Parameters:
//   DW    sample width (signed), 16..32
//   DIV   clock-enable divide ratio, 1..65535
//   SEED  LFSR reset value (0 is replaced by 16'hACE1)
//   DACW  DAC code width, 4..DW
//   SWAP  1 = emit DAC code as {lower half, upper half} for PMOD pin order
//
// Ports:
//   clk          system clock
//   reset_n      synchronous active-low reset
//   tone_in      signed tone sample (DW)
//   filt_in      signed filtered sample (DW)
//   mode         00 tone, 01 tone+noise, 10 noise only, 11 filt_in
//   noise_shift  arithmetic right shift applied to the noise
//   sat_clr      clears sat_count (wins over an increment in the same cycle)
//   en           sample-rate enable, one-cycle pulse every DIV cycles
//   mix_out      signed mixed sample (DW)
//   mix_valid    one-cycle strobe, mix_out updated
//   dac_out      offset-binary DAC code (DACW)
//   sat_count    number of saturated samples, sticks at 16'hFFFF
// ---------------------------------------------------------------------------
module noise_mix_dac #(
  parameter int          DW   = 16,
  parameter int          DIV  = 1,
  parameter logic [15:0] SEED = 16'hACE1,
  parameter int          DACW = 8,
  parameter int          SWAP = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic signed [DW-1:0] tone_in,
  input  logic signed [DW-1:0] filt_in,
  input  logic [1:0]           mode,
  input  logic [3:0]           noise_shift,
  input  logic                 sat_clr,
  output logic                 en,
  output logic signed [DW-1:0] mix_out,
  output logic                 mix_valid,
  output logic [DACW-1:0]      dac_out,
  output logic [15:0]          sat_count
);

  // Reorders a DAC code into pin order. Applied after the offset-binary
  // conversion so the midscale constant and live codes go through one path.
  function automatic logic [DACW-1:0] swap_halves(input logic [DACW-1:0] d);
    logic [DACW-1:0] r;
    if (SWAP != 0) r = {d[DACW/2-1:0], d[DACW-1:DACW/2]};
    else           r = d;
    return r;
  endfunction

  // An all-zero LFSR would lock up, so a zero seed falls back to the default.
  localparam logic [15:0]    SEED_L   = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [15:0]    DIV_LAST = 16'(DIV - 1);
  localparam logic [DACW-1:0] MID_CODE = {1'b1, {(DACW-1){1'b0}}};
  localparam logic [DACW-1:0] DAC_MID  = swap_halves(MID_CODE);
  localparam logic [DW-1:0]  SAT_MAX  = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0]  SAT_MIN  = {1'b1, {(DW-1){1'b0}}};

  localparam logic [1:0] MODE_TONE  = 2'b00;
  localparam logic [1:0] MODE_MIX   = 2'b01;
  localparam logic [1:0] MODE_NOISE = 2'b10;
  localparam logic [1:0] MODE_FILT  = 2'b11;

  // -------------------------------------------------------------------------
  // Clock-enable divider. en is registered from the next count so that it is
  // high exactly in the cycle where the count sits at DIV-1, and is still
  // forced low by reset even when DIV=1.
  // -------------------------------------------------------------------------
  logic [15:0] div_cnt;
  logic [15:0] div_cnt_nxt;

  always_comb begin
    div_cnt_nxt = (div_cnt == DIV_LAST) ? 16'd0 : div_cnt + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_cnt <= 16'd0;
      en      <= 1'b0;
    end else begin
      div_cnt <= div_cnt_nxt;
      en      <= (div_cnt_nxt == DIV_LAST);
    end
  end

  // -------------------------------------------------------------------------
  // Noise source: Fibonacci LFSR x^16+x^14+x^13+x^11+1, advanced on en.
  // The zero check runs every cycle so a corrupted register recovers without
  // waiting for the next sample tick.
  // -------------------------------------------------------------------------
  logic [15:0] lfsr;
  logic        lfsr_fb;

  always_comb begin
    lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lfsr <= SEED_L;
    end else if (lfsr == 16'h0000) begin
      lfsr <= SEED_L;
    end else if (en) begin
      lfsr <= {lfsr[14:0], lfsr_fb};
    end
  end

  // Noise as a signed DW-bit value, scaled down by noise_shift. Uses the LFSR
  // value from before the advance that happens on the same edge.
  logic signed [15:0]   lfsr_s;
  logic signed [DW-1:0] lfsr_ext;
  logic signed [DW-1:0] noise_scaled;

  always_comb begin
    lfsr_s       = $signed(lfsr);
    lfsr_ext     = DW'(lfsr_s);
    noise_scaled = lfsr_ext >>> noise_shift;
  end

  // -------------------------------------------------------------------------
  // Stage A: capture inputs on the sample tick. mode and noise_shift are only
  // looked at here, so changes between ticks do not affect samples in flight.
  // -------------------------------------------------------------------------
  logic signed [DW-1:0] tone_r;
  logic signed [DW-1:0] filt_r;
  logic signed [DW-1:0] noise_r;
  logic [1:0]           mode_r;
  logic                 a_valid;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tone_r  <= '0;
      filt_r  <= '0;
      noise_r <= '0;
      mode_r  <= MODE_TONE;
      a_valid <= 1'b0;
    end else begin
      a_valid <= en;
      if (en) begin
        tone_r  <= tone_in;
        filt_r  <= filt_in;
        noise_r <= noise_scaled;
        mode_r  <= mode;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stage B: select and saturate. The sum is one bit wider than the samples;
  // overflow shows up as disagreement between the top two bits of the sum,
  // and the top bit then gives the direction of the clamp.
  // -------------------------------------------------------------------------
  logic signed [DW:0]   sum_w;
  logic                 sum_ovf;
  logic signed [DW-1:0] sum_sat;
  logic signed [DW-1:0] mix_sel;
  logic                 clamp;

  always_comb begin
    sum_w   = (DW+1)'(tone_r) + (DW+1)'(noise_r);
    sum_ovf = sum_w[DW] ^ sum_w[DW-1];
    if (sum_ovf) sum_sat = sum_w[DW] ? SAT_MIN : SAT_MAX;
    else         sum_sat = sum_w[DW-1:0];

    mix_sel = tone_r;
    case (mode_r)
      MODE_TONE:  mix_sel = tone_r;
      MODE_MIX:   mix_sel = sum_sat;
      MODE_NOISE: mix_sel = noise_r;
      MODE_FILT:  mix_sel = filt_r;
      default:    mix_sel = tone_r;
    endcase

    // Only the tone+noise path adds two samples, so only it can clamp.
    clamp = a_valid && (mode_r == MODE_MIX) && sum_ovf;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mix_out   <= '0;
      mix_valid <= 1'b0;
    end else begin
      mix_valid <= a_valid;
      if (a_valid) begin
        mix_out <= mix_sel;
      end
    end
  end

  // Saturation counter: clear wins over increment, and it never wraps.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sat_count <= 16'd0;
    end else if (sat_clr) begin
      sat_count <= 16'd0;
    end else if (clamp && (sat_count != 16'hFFFF)) begin
      sat_count <= sat_count + 16'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Stage C: DAC formatting. Take the top DACW bits of the sample and flip
  // the sign bit to go from two's complement to offset binary, so the most
  // negative sample maps to code 0 and zero maps to midscale.
  // -------------------------------------------------------------------------
  logic [DACW-1:0] dac_raw;
  logic [DACW-1:0] dac_fmt;

  always_comb begin
    dac_raw          = mix_out[DW-1 -: DACW];
    dac_raw[DACW-1]  = ~mix_out[DW-1];
    dac_fmt          = swap_halves(dac_raw);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dac_out <= DAC_MID;
    end else if (mix_valid) begin
      dac_out <= dac_fmt;
    end
  end

endmodule

// File: doc/noise_mix_dac.md
Name: noise_mix_dac

Overview:
Parametrised front end for the audio filter chain. It generates the sample-rate clock enable and the LFSR noise, then mixes tone, scaled noise or filter output under mode control with saturation. It also formats the result for the 8-bit PMOD DAC. It generalises the fixed tone+noise glue logic: adjustable width, divider, noise level, modes, overflow counting and DAC pin ordering.

Parameters:
DW, 16, sample width in bits, signed two's complement; legal range 16..32.
DIV, 1, clock-enable divide ratio; legal range 1..65535.
SEED, 16'hACE1, LFSR reset value; 0 is illegal and is replaced by 16'hACE1.
DACW, 8, DAC output width; legal range 4..DW.
SWAP, 1, 1 = swap DAC output halves ({lower half, upper half}) to match PMOD pin order.

Ports:
clk  in  1  system clock (19.8 MHz domain)
reset_n  in  1  synchronous active-low reset
tone_in  in  DW  signed tone sample
filt_in  in  DW  signed filtered sample
mode  in  2  00 tone, 01 tone+noise, 10 noise only, 11 filt_in
noise_shift  in  4  arithmetic right shift applied to the noise
sat_clr  in  1  clears sat_count
en  out  1  sample-rate clock enable, one-cycle pulse
mix_out  out  DW  signed mixed sample
mix_valid  out  1  one-cycle strobe, mix_out updated
dac_out  out  DACW  offset-binary DAC code
sat_count  out  16  count of saturated samples

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - divider = 0; lfsr = SEED.
  - en, mix_valid, mix_out, sat_count = 0.
  - dac_out = midscale (MSB set, i.e. 8'h80); with SWAP=1 this is 8'h08.
- Divider:
  - Counts 0..DIV-1.
  - en = 1 in the cycle where count == DIV-1, else 0.
  - DIV=1 gives en = 1 every cycle after reset release.
- LFSR:
  - 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - fb = l[15]^l[13]^l[12]^l[10]; next = {l[14:0], fb}.
  - Advances only on en.
  - If lfsr == 0 is detected, it reloads SEED on the next edge regardless of en.
- Stage A (edge where en=1):
  - Capture tone_in, filt_in and mode.
  - noise_r = sign-extend-to-DW(lfsr) >>> noise_shift, using the lfsr value before the advance.
  - lfsr advances on the same edge.
- Stage B (next edge):
  - Select: tone_r; tone_r+noise_r; noise_r; or filt_r.
  - The sum is formed at DW+1 bits and saturated to [-2^(DW-1), 2^(DW-1)-1].
  - Register into mix_out; mix_valid = 1 for exactly this one cycle.
- Stage C (next edge):
  - d = mix_out[DW-1 -: DACW] with the MSB inverted (offset binary).
  - dac_out = SWAP ? {d[DACW/2-1:0], d[DACW-1:DACW/2]} : d.
- Latency: en high in cycle n → mix_out/mix_valid visible in cycle n+2 → dac_out visible in cycle n+3.
- Saturation counter:
  - Increments when a stage-B result clamps (mode 01 only; other modes cannot overflow).
  - Sticks at 16'hFFFF.
  - sat_clr has priority over increment in the same cycle.
- Input capture rules:
  - mode and noise_shift changes take effect only at the next en.
  - Samples already in the pipeline complete with their captured mode.
- Back-to-back operation (DIV=1): stages pipeline fully; one result per cycle, mix_valid held high continuously.
- Reset mid-pipeline:
  - All in-flight samples are discarded; no mix_valid follows.
  - dac_out returns to midscale.

Test Plan:
- Reset, DIV=4, hold 10 cycles → en pulses at cycles 3 and 7 after release; en low otherwise; dac_out=8'h08 (SWAP=1) before the first sample.
- SEED=16'hACE1, mode=10, noise_shift=0, DW=16 → first mix_out=16'hACE1 in cycle 2 after the first en, second=16'h59C3; noise_shift=4 with lfsr 16'hACE1 → 16'hFACE.
- mode=00, tone_in=16'h7FFF, SWAP=0 → mix_out=16'h7FFF, dac_out=8'hFF; tone_in=16'h8000 → dac_out=8'h00; SWAP=1 with tone_in=16'h1200 → dac_out=8'h29.
- mode=01, tone_in=16'h7FFF, lfsr=16'h0001 (SEED=1), shift 0 → mix_out=16'h7FFF, sat_count=1; repeat with sat_clr asserted on the increment cycle → sat_count=0.
- DIV=1, mode switched 00→11 mid-stream → exactly the samples captured after the switch show filt_in; mix_valid continuous; latency 2 cycles.
- Assert reset_n=0 one cycle after en → no mix_valid; lfsr=SEED, sat_count=0, dac_out midscale on the following cycle.
